// File: rtl/alu_result_store.sv
// rtl/alu_result_store.sv - debounced capture of the ALU result into an accumulator with a 4-entry history
//
// Purpose: holds the ALU's 8-bit result when a debounced push-button request
// arrives. The low nibble is fed back as the ALU B operand, and the last four
// captures are kept for display selection.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   capture_req    in   raw push-button level, asynchronous to clk
//   clr            in   synchronous clear of all stored data
//   alu_result     in   [7:0] ALU output
//   alu_func       in   [2:0] ALU function code for alu_result
//   hist_sel       in   [1:0] history read index, 0 = newest
//   acc_q          out  [7:0] accumulator
//   operand_b      out  [3:0] acc_q[3:0]
//   last_func      out  [2:0] function code of the latest capture
//   acc_zero       out  acc_q == 0
//   hist_q         out  [7:0] selected history entry, 0 when not valid
//   hist_count     out  [2:0] number of valid history entries (0..4)
//   captured_pulse out  one-cycle strobe after each capture
module alu_result_store #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HIST_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       capture_req,
  input  logic       clr,
  input  logic [7:0] alu_result,
  input  logic [2:0] alu_func,
  input  logic [1:0] hist_sel,
  output logic [7:0] acc_q,
  output logic [3:0] operand_b,
  output logic [2:0] last_func,
  output logic       acc_zero,
  output logic [7:0] hist_q,
  output logic [2:0] hist_count,
  output logic       captured_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    CAPTURE  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q;
  logic          req_s;
  logic          capture_en;

  logic [7:0]    acc_reg_q;
  logic [2:0]    func_q;
  logic [7:0]    hist_mem_q [HIST_DEPTH];
  logic [1:0]    wr_ptr_q;
  logic [2:0]    hist_count_q;
  logic          pulse_q;
  logic [1:0]    rd_idx;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= capture_req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          if (!req_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        CAPTURE: begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
        RELEASE: begin
          // Any high sample restarts the low-time count, so a short glitch
          // during a long press cannot re-arm the capture.
          if (req_s) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A clear in the CAPTURE cycle suppresses the capture.
  assign capture_en = (state_q == CAPTURE) && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg_q    <= '0;
      func_q       <= '0;
      wr_ptr_q     <= '0;
      hist_count_q <= '0;
      pulse_q      <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem_q[i] <= '0;
    end else if (clr) begin
      acc_reg_q    <= '0;
      func_q       <= '0;
      wr_ptr_q     <= '0;
      hist_count_q <= '0;
      pulse_q      <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem_q[i] <= '0;
    end else begin
      pulse_q <= capture_en;
      if (capture_en) begin
        acc_reg_q            <= alu_result;
        func_q               <= alu_func;
        hist_mem_q[wr_ptr_q] <= alu_result;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
        if (hist_count_q != 3'd4) hist_count_q <= hist_count_q + 3'd1;
      end
    end
  end

  // Newest entry sits just behind the write pointer; 2-bit wrap gives mod 4.
  assign rd_idx = wr_ptr_q - 2'd1 - hist_sel;

  assign acc_q          = acc_reg_q;
  assign operand_b      = acc_reg_q[3:0];
  assign acc_zero       = (acc_reg_q == 8'h00);
  assign last_func      = func_q;
  assign hist_count     = hist_count_q;
  assign captured_pulse = pulse_q;
  assign hist_q         = ({1'b0, hist_sel} < hist_count_q) ? hist_mem_q[rd_idx] : 8'h00;

endmodule

// File: tb/tb_alu_result_store.sv
// tb/tb_alu_result_store.sv - directed self-checking bench for alu_result_store
module tb_alu_result_store;

  logic       clk;
  logic       reset;
  logic       capture_req;
  logic       clr;
  logic [7:0] alu_result;
  logic [2:0] alu_func;
  logic [1:0] hist_sel;
  logic [7:0] acc_q;
  logic [3:0] operand_b;
  logic [2:0] last_func;
  logic       acc_zero;
  logic [7:0] hist_q;
  logic [2:0] hist_count;
  logic       captured_pulse;

  int total;
  int bad;

  alu_result_store #(.DEBOUNCE_CYCLES(4), .HIST_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .capture_req    (capture_req),
    .clr            (clr),
    .alu_result     (alu_result),
    .alu_func       (alu_func),
    .hist_sel       (hist_sel),
    .acc_q          (acc_q),
    .operand_b      (operand_b),
    .last_func      (last_func),
    .acc_zero       (acc_zero),
    .hist_q         (hist_q),
    .hist_count     (hist_count),
    .captured_pulse (captured_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // One press long enough to capture, then long enough low to re-arm.
  task automatic press(input logic [7:0] val, input logic [2:0] fn);
    alu_result  = val;
    alu_func    = fn;
    capture_req = 1'b1;
    repeat (12) step();
    capture_req = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; capture_req = 1'b0; clr = 1'b0;
    alu_result = 8'h00; alu_func = 3'd0; hist_sel = 2'd0;
    repeat (3) step();
    reset = 1'b0;
    step();
    total++;
    if (acc_q !== 8'h00 || acc_zero !== 1'b1 || captured_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: acc=%h zero=%b pulse=%b, required acc=00 zero=1 pulse=0", acc_q, acc_zero, captured_pulse);
    end
    total++;
    if (hist_count !== 3'd0 || last_func !== 3'd0 || hist_q !== 8'h00) begin
      bad++;
      $display("FAIL reset_hist: count=%0d func=%0d hist=%h, required 0 0 00", hist_count, last_func, hist_q);
    end
  endtask

  task automatic test_capture_latency();
    int pulses;
    pulses = 0;
    alu_result = 8'h2C; alu_func = 3'b101; capture_req = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 9) alu_result = 8'h77;
      if (captured_pulse === 1'b1) pulses++;
      if (e == 7) begin
        total++;
        if (acc_q !== 8'h00) begin
          bad++;
          $display("FAIL latency_early: edge7 acc=%h, required 00", acc_q);
        end
      end
      if (e == 8) begin
        total++;
        if (acc_q !== 8'h2C || captured_pulse !== 1'b1) begin
          bad++;
          $display("FAIL latency_edge8: acc=%h pulse=%b, required 2c 1", acc_q, captured_pulse);
        end
      end
    end
    capture_req = 1'b0;
    repeat (10) step();
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL capture_pulse_count: got %0d, required 1", pulses);
    end
    total++;
    if (acc_q !== 8'h2C || operand_b !== 4'hC || last_func !== 3'b101 || acc_zero !== 1'b0) begin
      bad++;
      $display("FAIL capture_outputs: acc=%h opb=%h func=%b zero=%b, required 2c c 101 0", acc_q, operand_b, last_func, acc_zero);
    end
    hist_sel = 2'd0;
    #1;
    total++;
    if (hist_count !== 3'd1 || hist_q !== 8'h2C) begin
      bad++;
      $display("FAIL capture_hist: count=%0d hist=%h, required 1 2c", hist_count, hist_q);
    end
  endtask

  task automatic test_short_pulse();
    int pulses;
    pulses = 0;
    alu_result = 8'h99; alu_func = 3'd2;
    capture_req = 1'b1;
    repeat (3) begin step(); if (captured_pulse === 1'b1) pulses++; end
    capture_req = 1'b0;
    repeat (15) begin step(); if (captured_pulse === 1'b1) pulses++; end
    total++;
    if (pulses !== 0 || acc_q !== 8'h2C || hist_count !== 3'd1) begin
      bad++;
      $display("FAIL short_pulse: pulses=%0d acc=%h count=%0d, required 0 2c 1", pulses, acc_q, hist_count);
    end
  endtask

  task automatic test_history_wrap();
    logic [7:0] exp_hist [4];
    exp_hist[0] = 8'h05; exp_hist[1] = 8'h04; exp_hist[2] = 8'h03; exp_hist[3] = 8'h02;
    do_clr();
    for (int k = 1; k <= 5; k++) press(8'(k), 3'(k));
    total++;
    if (hist_count !== 3'd4 || acc_q !== 8'h05 || last_func !== 3'd5) begin
      bad++;
      $display("FAIL hist_full: count=%0d acc=%h func=%0d, required 4 05 5", hist_count, acc_q, last_func);
    end
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      total++;
      if (hist_q !== exp_hist[s]) begin
        bad++;
        $display("FAIL hist_sel%0d: got %h, required %h", s, hist_q, exp_hist[s]);
      end
    end
  endtask

  task automatic test_clr();
    do_clr();
    press(8'h11, 3'd1);
    press(8'h22, 3'd6);
    hist_sel = 2'd3;
    #1;
    total++;
    if (hist_q !== 8'h00) begin
      bad++;
      $display("FAIL hist_invalid_sel: got %h, required 00", hist_q);
    end
    hist_sel = 2'd1;
    #1;
    total++;
    if (hist_q !== 8'h11 || hist_count !== 3'd2) begin
      bad++;
      $display("FAIL hist_two: hist=%h count=%0d, required 11 2", hist_q, hist_count);
    end
    do_clr();
    hist_sel = 2'd0;
    #1;
    total++;
    if (acc_q !== 8'h00 || acc_zero !== 1'b1 || hist_count !== 3'd0 || last_func !== 3'd0 || hist_q !== 8'h00) begin
      bad++;
      $display("FAIL clr_state: acc=%h zero=%b count=%0d func=%0d hist=%h, required 00 1 0 0 00", acc_q, acc_zero, hist_count, last_func, hist_q);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses;
    pulses = 0;
    alu_result = 8'hFF; alu_func = 3'd7;
    capture_req = 1'b1;
    repeat (5) step();
    #2;
    reset = 1'b1;
    capture_req = 1'b0;
    #1;
    total++;
    if (acc_q !== 8'h00 || captured_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: acc=%h pulse=%b, required 00 0", acc_q, captured_pulse);
    end
    step();
    reset = 1'b0;
    repeat (15) begin step(); if (captured_pulse === 1'b1) pulses++; end
    total++;
    if (pulses !== 0 || acc_q !== 8'h00 || hist_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_abort: pulses=%0d acc=%h count=%0d, required 0 00 0", pulses, acc_q, hist_count);
    end
    // A fresh press must see the full latency again, proving the FSM restarted in IDLE.
    alu_result = 8'h3A; capture_req = 1'b1;
    repeat (7) step();
    total++;
    if (acc_q !== 8'h00) begin
      bad++;
      $display("FAIL reset_relatency_early: acc=%h, required 00", acc_q);
    end
    step();
    total++;
    if (acc_q !== 8'h3A) begin
      bad++;
      $display("FAIL reset_relatency: acc=%h, required 3a", acc_q);
    end
    capture_req = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_glitch_hold();
    int pulses;
    pulses = 0;
    do_clr();
    alu_result = 8'h5A; alu_func = 3'd3;
    capture_req = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      capture_req = (c == 50 || c == 51) ? 1'b0 : 1'b1;
      if (c == 20) alu_result = 8'hC3;
      step();
      if (captured_pulse === 1'b1) pulses++;
    end
    capture_req = 1'b0;
    repeat (10) begin step(); if (captured_pulse === 1'b1) pulses++; end
    total++;
    if (pulses !== 1 || hist_count !== 3'd1 || acc_q !== 8'h5A) begin
      bad++;
      $display("FAIL glitch_hold: pulses=%0d count=%0d acc=%h, required 1 1 5a", pulses, hist_count, acc_q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_capture_latency();
    test_short_pulse();
    test_history_wrap();
    test_clr();
    test_reset_mid_debounce();
    test_glitch_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
